// File: rtl/rgmii_pkg.sv
// -----------------------------------------------------------------------------
// rgmii_pkg
//   Shared constants and types for the RGMII receive path.
//   - Ethernet preamble / start-of-frame-delimiter byte values
//   - CRC-32 polynomial, init value and good-frame residue, plus a one-byte
//     CRC step used by the optional FCS checker
//   - Frame FSM state encoding
//   - Aligned per-cycle receive beat {dv, er, data}
// -----------------------------------------------------------------------------
package rgmii_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC32_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFF_FFFF;
  // Register value left after running the CRC over a frame including a
  // correct FCS (MSB-first register, bytes fed LSB-first).
  localparam logic [31:0] CRC32_RESIDUE = 32'hC704_DD7B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } rx_state_e;

  typedef struct packed {
    logic       dv;
    logic       er;
    logic [7:0] data;
  } rx_beat_t;

  // One byte of the Ethernet CRC: data enters LSB first, register shifts
  // towards the MSB, so the plain (non-reflected) polynomial is used.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                             input logic [7:0]  data);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC32_POLY;
      else                 c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/rgmii_rx_ddr.sv
// -----------------------------------------------------------------------------
// rgmii_rx_ddr
//   Behavioural equivalent of one IDDR per RGMII receive pin in
//   SAME_EDGE_PIPELINED mode. The rising-edge nibble carries byte[3:0] and
//   DV; the falling-edge nibble carries byte[7:4] and DV^ER. Both halves are
//   re-registered on the next rising edge so that a complete beat
//   {dv, er, byte} is presented once per rgmii_rxc cycle.
//   This is the only file that would change when targeting vendor primitives.
//
// Ports
//   rgmii_rxc  in   receive clock, both edges used
//   rst_n      in   asynchronous active-low reset
//   rgmii_rxv  in   RX_CTL pin
//   rgmii_rxd  in   4-bit DDR data pins
//   o_beat     out  aligned {dv, er, data}, valid on the rising edge
//   o_rdy      out  high once the capture pipeline holds genuine line data
//                   (two rising edges after reset release)
// -----------------------------------------------------------------------------
module rgmii_rx_ddr
  import rgmii_pkg::*;
(
  input  logic       rgmii_rxc,
  input  logic       rst_n,
  input  logic       rgmii_rxv,
  input  logic [3:0] rgmii_rxd,
  output rx_beat_t   o_beat,
  output logic       o_rdy
);

  // {ctl, data[3:0]} captured on each clock edge
  logic [4:0] r_rise;
  logic [4:0] r_fall;
  rx_beat_t   r_beat;
  logic [1:0] r_rdy_sr;

  // NOTE: clocked state is assigned with <= so every flop samples the
  // pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge rgmii_rxc or negedge rst_n) begin
    if (!rst_n) r_rise <= '0;
    else        r_rise <= {rgmii_rxv, rgmii_rxd};
  end

  always_ff @(negedge rgmii_rxc or negedge rst_n) begin
    if (!rst_n) r_fall <= '0;
    else        r_fall <= {rgmii_rxv, rgmii_rxd};
  end

  // Same-edge realignment: the falling half captured after a rising half
  // belongs to the same byte, so both are pulled onto the next rising edge.
  always_ff @(posedge rgmii_rxc or negedge rst_n) begin
    if (!rst_n) begin
      r_beat   <= '0;
      r_rdy_sr <= '0;
    end else begin
      r_beat.dv   <= r_rise[4];
      r_beat.er   <= r_rise[4] ^ r_fall[4];
      r_beat.data <= {r_fall[3:0], r_rise[3:0]};
      r_rdy_sr    <= {r_rdy_sr[0], 1'b1};
    end
  end

  assign o_beat = r_beat;
  assign o_rdy  = r_rdy_sr[1];

endmodule

// File: rtl/rgmii_rx_frame.sv
// -----------------------------------------------------------------------------
// rgmii_rx_frame
//   RGMII receive framer. Captures the DDR bus into bytes (rgmii_rx_ddr),
//   strips preamble and SFD, and delivers the post-SFD bytes (destination MAC
//   first, FCS last) as a byte stream with start/end-of-frame markers, an
//   error flag and the frame length. Entirely in the rgmii_rxc domain.
//
//   A one-byte hold register sits in front of the output register so that the
//   byte preceding the fall of DV can be tagged as the last byte.
//   Latency from a byte's rising-edge nibble to mac_rxd: 3 rising edges.
//
//   Optional build macro RGMII_RX_FCS_CHECK_EN: adds a CRC-32 over all
//   post-SFD bytes; a bad residue at end of frame is ORed into mac_rx_err.
//   Without it, mac_rx_err reports only RX_ER and length overflow.
//
// Parameters
//   MAX_FRAME_LEN  max post-SFD bytes (incl. FCS) before truncation
//   LEN_W          width of mac_rx_len
//
// Ports
//   rgmii_rxc   in   PHY receive clock (both edges used by capture)
//   rst_n       in   asynchronous active-low reset
//   rgmii_rxv   in   RX_CTL: DV on rising edge, DV^ER on falling edge
//   rgmii_rxd   in   DDR data: [3:0] rising, [7:4] falling
//   mac_rxv     out  mac_rxd valid
//   mac_rxd     out  received byte
//   mac_rx_sof  out  first byte of frame
//   mac_rx_eof  out  last byte of frame
//   mac_rx_err  out  frame error, meaningful with mac_rx_eof only
//   mac_rx_len  out  delivered byte count, meaningful with mac_rx_eof only
// -----------------------------------------------------------------------------
module rgmii_rx_frame
  import rgmii_pkg::*;
#(
  parameter int MAX_FRAME_LEN = 1522,
  parameter int LEN_W         = 16
) (
  input  logic             rgmii_rxc,
  input  logic             rst_n,
  input  logic             rgmii_rxv,
  input  logic [3:0]       rgmii_rxd,
  output logic             mac_rxv,
  output logic [7:0]       mac_rxd,
  output logic             mac_rx_sof,
  output logic             mac_rx_eof,
  output logic             mac_rx_err,
  output logic [LEN_W-1:0] mac_rx_len
);

  rx_beat_t   w_beat;
  logic       w_rdy;

  rx_state_e  r_state;
  rx_state_e  w_state_nxt;

  logic [7:0]       r_hold;
  logic             r_hold_vld;
  logic [LEN_W-1:0] r_count;
  logic             r_err;
  logic             r_sof_pend;
  // Set once the line has been seen idle after reset; until then a frame
  // already in flight must not be mistaken for a new one.
  logic             r_line_idle;

  logic w_start;   // SFD accepted: arm a new frame
  logic w_load;    // current byte enters the hold register
  logic w_emit;    // held byte goes to the output register
  logic w_eof;     // held byte is the last one of the frame
  logic w_ovf;     // another byte arrives with the frame already at max length
  logic w_fcs_bad;

  // ---------------------------------------------------------------------------
  // Capture
  // ---------------------------------------------------------------------------
  rgmii_rx_ddr u_ddr (
    .rgmii_rxc (rgmii_rxc),
    .rst_n     (rst_n),
    .rgmii_rxv (rgmii_rxv),
    .rgmii_rxd (rgmii_rxd),
    .o_beat    (w_beat),
    .o_rdy     (w_rdy)
  );

  // ---------------------------------------------------------------------------
  // Frame FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge rgmii_rxc or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // Frame FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: a default before the case keeps every path assigned, so no latch
    // is inferred.
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_beat.dv) begin
          if (r_line_idle && (w_beat.data == PREAMBLE_BYTE)) w_state_nxt = PRE;
          else                                               w_state_nxt = DROP;
        end
      end
      PRE: begin
        if (!w_beat.dv)                         w_state_nxt = IDLE;
        else if (w_beat.data == PREAMBLE_BYTE)  w_state_nxt = PRE;
        else if (w_beat.data == SFD_BYTE)       w_state_nxt = DATA;
        else                                    w_state_nxt = DROP;
      end
      DATA: begin
        if (!w_beat.dv) w_state_nxt = IDLE;
        else if (w_ovf) w_state_nxt = DROP;
      end
      DROP: begin
        if (!w_beat.dv) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame FSM: outputs (datapath controls)
  // ---------------------------------------------------------------------------
  assign w_ovf = (r_state == DATA) && w_beat.dv &&
                 (r_count == LEN_W'(MAX_FRAME_LEN));

  always_comb begin
    w_start = 1'b0;
    w_load  = 1'b0;
    w_emit  = 1'b0;
    w_eof   = 1'b0;
    case (r_state)
      PRE: begin
        w_start = w_beat.dv && (w_beat.data == SFD_BYTE);
      end
      DATA: begin
        // The held byte always leaves on the next DATA edge; it is the last
        // one when DV has dropped or the length limit cuts the frame.
        w_emit = r_hold_vld;
        w_eof  = r_hold_vld && (!w_beat.dv || w_ovf);
        w_load = w_beat.dv && !w_ovf;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Hold register, byte counter, sticky error
  // ---------------------------------------------------------------------------
  always_ff @(posedge rgmii_rxc or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the hold byte is a plain data register and is reset along with
      // its valid flag, so nothing stale can ever reach mac_rxd.
      r_hold      <= '0;
      r_hold_vld  <= 1'b0;
      r_count     <= '0;
      r_err       <= 1'b0;
      r_sof_pend  <= 1'b0;
      r_line_idle <= 1'b0;
    end else begin
      // The first two beats after reset are pipeline fill, not line state.
      if (w_rdy && !w_beat.dv) r_line_idle <= 1'b1;

      if (w_start) begin
        r_hold_vld <= 1'b0;
        r_count    <= '0;
        r_err      <= 1'b0;
        r_sof_pend <= 1'b1;
      end else begin
        if (w_load) begin
          r_hold     <= w_beat.data;
          r_hold_vld <= 1'b1;
          r_count    <= r_count + 1'b1;
          if (w_beat.er) r_err <= 1'b1;
        end
        if (w_emit) r_sof_pend <= 1'b0;
        if (w_eof)  r_hold_vld <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional FCS check
  // ---------------------------------------------------------------------------
`ifdef RGMII_RX_FCS_CHECK_EN
  logic [31:0] r_crc;

  always_ff @(posedge rgmii_rxc or negedge rst_n) begin
    if (!rst_n)      r_crc <= '0;
    else if (w_start) r_crc <= CRC32_INIT;
    else if (w_load)  r_crc <= crc32_byte(r_crc, w_beat.data);
  end

  // By the eof edge every delivered byte, FCS included, has been folded in.
  assign w_fcs_bad = (r_crc != CRC32_RESIDUE);
`else
  assign w_fcs_bad = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  always_ff @(posedge rgmii_rxc or negedge rst_n) begin
    if (!rst_n) begin
      mac_rxv    <= 1'b0;
      mac_rxd    <= '0;
      mac_rx_sof <= 1'b0;
      mac_rx_eof <= 1'b0;
      mac_rx_err <= 1'b0;
      mac_rx_len <= '0;
    end else begin
      mac_rxv    <= w_emit;
      mac_rxd    <= w_emit ? r_hold : 8'h00;
      mac_rx_sof <= w_emit && r_sof_pend;
      mac_rx_eof <= w_eof;
      mac_rx_err <= w_eof && (r_err || w_ovf || w_fcs_bad);
      mac_rx_len <= w_eof ? r_count : '0;
    end
  end

endmodule
